// File: rtl/bcd_scan4.sv
// Four-digit multiplexed BCD display scanner feeding a shared seven-segment decoder.
// Double-buffers value updates to the frame boundary and blanks leading zeros / non-BCD nibbles.
module bcd_scan4 #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] din,
    output logic [3:0]  digit,
    output logic [3:0]  sel,
    output logic        blank,
    output logic        pending,
    output logic        frame_done
);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] act_q, act_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic        frame_done_q, frame_done_d;

    logic        tick, wrap;
    logic [3:0]  n;
    logic        lead_zero, invalid;

    assign tick = (cnt_q == 16'(DIV - 1));
    assign wrap = tick && (idx_q == 2'd3);

    always_comb begin
        cnt_d        = tick ? 16'd0 : cnt_q + 16'd1;
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        frame_done_d = wrap;
        if (wrap) begin
            // A load landing on the boundary bypasses the buffer; any older pending value is dropped.
            if (load) begin
                act_d    = din;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (load) begin
            pend_d   = din;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Output decode uses only registered state, so load/din never reach the decoder combinationally.
    assign n       = act_q[{idx_q, 2'b00} +: 4];
    assign invalid = (n > 4'd9);

    always_comb begin
        lead_zero = 1'b0;
        case (idx_q)
            2'd1:    lead_zero = (act_q[15:4] == 12'd0);
            2'd2:    lead_zero = (act_q[15:8] == 8'd0);
            2'd3:    lead_zero = (act_q[15:12] == 4'd0);
            default: lead_zero = 1'b0;
        endcase
    end

    assign blank      = invalid || lead_zero;
    assign digit      = blank ? 4'd0 : n;
    assign sel        = blank ? 4'b0000 : (4'b0001 << idx_q);
    assign pending    = pend_v_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan4.sv
// Self-checking bench for bcd_scan4 (DIV=4): expected slot contents are queued per frame and
// compared cycle by cycle while the frame scans out.
module tb_bcd_scan4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] din;
    logic [3:0]  digit;
    logic [3:0]  sel;
    logic        blank;
    logic        pending;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] digit;
        logic       blank;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    bcd_scan4 #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .load(load), .din(din),
        .digit(digit), .sel(sel), .blank(blank),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int m);
        for (int i = 0; i < 4 * DIV; i++) begin
            if (cyc % (4 * DIV) == m) break;
            step();
        end
    endtask

    task automatic push_slot(input logic [3:0] s, input logic [3:0] d, input logic b);
        exp_t e;
        e.sel = s; e.digit = d; e.blank = b;
        exp_q.push_back(e);
    endtask

    // Compares one full frame starting at a frame boundary against the next four queued slots.
    task automatic check_frame(input string name);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s: scoreboard empty at slot %0d", name, s);
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            for (int k = 0; k < DIV; k++) begin
                checks++;
                if ({sel, digit, blank} !== {e.sel, e.digit, e.blank}) begin
                    failures++;
                    $display("FAIL %s slot%0d cyc%0d: got sel=%b digit=%0d blank=%b, want sel=%b digit=%0d blank=%b",
                             name, s, k, sel, digit, blank, e.sel, e.digit, e.blank);
                end
                checks++;
                if (frame_done !== (s == 0 && k == 0)) begin
                    failures++;
                    $display("FAIL %s frame_done slot%0d cyc%0d: got %b want %b",
                             name, s, k, frame_done, (s == 0 && k == 0));
                end
                step();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; din = 16'h9999;
        step();
        step();
        reset = 1'b0; load = 1'b0;
        cyc = 0;
        checks++;
        if ({digit, sel, blank, pending, frame_done} !== {4'd0, 4'b0001, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got digit=%0d sel=%b blank=%b pending=%b frame_done=%b, want 0 0001 0 0 0",
                     digit, sel, blank, pending, frame_done);
        end
    endtask

    task automatic test_scan();
        din = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL scan_pending_rise: got %b want 1", pending);
        end
        push_slot(4'b0001, 4'd4, 1'b0);
        push_slot(4'b0010, 4'd3, 1'b0);
        push_slot(4'b0100, 4'd2, 1'b0);
        push_slot(4'b1000, 4'd1, 1'b0);
        advance_to(0);
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL scan_pending_fall: got %b want 0", pending);
        end
        check_frame("scan_1234");
    endtask

    task automatic test_tear_free();
        advance_to(5);
        din = 16'h5678; load = 1'b1;
        step();
        load = 1'b0;
        step();
        din = 16'h9012; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if ({sel, digit, pending} !== {4'b0100, 4'd2, 1'b1}) begin
            failures++;
            $display("FAIL tear_mid_frame: got sel=%b digit=%0d pending=%b, want 0100 2 1", sel, digit, pending);
        end
        advance_to(12);
        checks++;
        if ({sel, digit, pending} !== {4'b1000, 4'd1, 1'b1}) begin
            failures++;
            $display("FAIL tear_last_slot: got sel=%b digit=%0d pending=%b, want 1000 1 1", sel, digit, pending);
        end
        push_slot(4'b0001, 4'd2, 1'b0);
        push_slot(4'b0010, 4'd1, 1'b0);
        push_slot(4'b0100, 4'd0, 1'b0);
        push_slot(4'b1000, 4'd9, 1'b0);
        advance_to(0);
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL tear_pending_fall: got %b want 0", pending);
        end
        check_frame("tear_9012");
    endtask

    task automatic test_load_on_wrap();
        advance_to(15);
        din = 16'h0042; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if ({digit, sel, pending} !== {4'd2, 4'b0001, 1'b0}) begin
            failures++;
            $display("FAIL wrap_load: got digit=%0d sel=%b pending=%b, want 2 0001 0", digit, sel, pending);
        end
        push_slot(4'b0001, 4'd2, 1'b0);
        push_slot(4'b0010, 4'd4, 1'b0);
        push_slot(4'b0000, 4'd0, 1'b1);
        push_slot(4'b0000, 4'd0, 1'b1);
        check_frame("wrap_0042");
    endtask

    task automatic load_and_wait(input logic [15:0] v);
        advance_to(1);
        din = v; load = 1'b1;
        step();
        load = 1'b0;
        advance_to(0);
    endtask

    task automatic test_blanking();
        push_slot(4'b0001, 4'd0, 1'b0);
        push_slot(4'b0000, 4'd0, 1'b1);
        push_slot(4'b0000, 4'd0, 1'b1);
        push_slot(4'b0000, 4'd0, 1'b1);
        load_and_wait(16'h0000);
        check_frame("blank_0000");
        push_slot(4'b0001, 4'd0, 1'b0);
        push_slot(4'b0010, 4'd0, 1'b0);
        push_slot(4'b0100, 4'd0, 1'b0);
        push_slot(4'b1000, 4'd1, 1'b0);
        load_and_wait(16'h1000);
        check_frame("blank_1000");
    endtask

    task automatic test_invalid_bcd();
        push_slot(4'b0001, 4'd5, 1'b0);
        push_slot(4'b0010, 4'd0, 1'b0);
        push_slot(4'b0000, 4'd0, 1'b1);
        push_slot(4'b1000, 4'd3, 1'b0);
        load_and_wait(16'h3A05);
        check_frame("invalid_3A05");
    endtask

    task automatic test_reset_mid();
        advance_to(1);
        din = 16'h7777; load = 1'b1;
        step();
        load = 1'b0;
        advance_to(8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        checks++;
        if ({sel, digit, pending, frame_done} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid: got sel=%b digit=%0d pending=%b frame_done=%b, want 0001 0 0 0",
                     sel, digit, pending, frame_done);
        end
        push_slot(4'b0001, 4'd0, 1'b0);
        push_slot(4'b0000, 4'd0, 1'b1);
        push_slot(4'b0000, 4'd0, 1'b1);
        push_slot(4'b0000, 4'd0, 1'b1);
        advance_to(0);
        step();
        advance_to(0);
        check_frame("reset_mid_frame");
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; din = '0;
        #2;
        test_reset();
        test_scan();
        test_tear_free();
        test_load_on_wrap();
        test_blanking();
        test_invalid_bcd();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_scan4.md
# bcd_scan4

Four-digit multiplexed display scanner sitting directly upstream of the BCD-to-seven-segment decoder. Holds a 16-bit packed BCD value, time-multiplexes one digit at a time onto a 4-bit `digit` bus that feeds the decoder, and drives the matching one-hot digit select. Adds double-buffered, tear-free value updates and leading-zero blanking, so the shared decoder only sees clean, stable nibbles.

## Interface
- `DIV`, default 4: clock cycles each digit stays active; legal range 2..65535.
- `clk`  in  1  system clock, all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle strobe; capture `din`.
- `din`  in  16  packed BCD, [15:12] = digit 3 (most significant) … [3:0] = digit 0.
- `digit`  out  4  BCD nibble for the active digit, to the decoder input.
- `sel`  out  4  one-hot active-high digit enable; bit i = digit i.
- `blank`  out  1  1 = active digit suppressed; `sel` = 0 while set.
- `pending`  out  1  a loaded value is waiting for the frame boundary.
- `frame_done`  out  1  one-cycle pulse when digit 3 finishes its slot.

## Operation
- State: prescale counter `cnt` (0..DIV-1), digit index `idx` (0..3), active register `act[15:0]`, pending register `pend[15:0]`, flag `pend_v`.
- `tick` = (`cnt` == DIV-1). On tick, `cnt` goes to 0 and `idx` increments, wrapping 3 to 0. Otherwise `cnt` increments.
- `wrap` = `tick` and `idx` == 3. `frame_done` is registered and is 1 in the cycle after `wrap`.
- Load without wrap: `pend` <= `din`, `pend_v` <= 1. Repeated loads before a wrap: the last one wins.
- Wrap without load: if `pend_v`, then `act` <= `pend` and `pend_v` <= 0.
- Load and wrap in the same cycle: `act` <= `din` directly and `pend_v` <= 0. Any older `pend` is discarded.
- `pending` = `pend_v`.
- Nibble selection: `n` = `act`[4·idx+3 : 4·idx]. `digit` = `n` when `n` ≤ 9, else 0.
- Blank conditions:
  - `n` > 9 (invalid BCD). The decoder is never given a non-BCD code.
  - Leading zero: `idx` ≥ 1, `n` == 0, and every more-significant nibble of `act` is 0.
  - Digit 0 is never blanked for leading zero, so a value of 0 shows a single "0".
- When `blank` = 1: `sel` = 4'b0000 and `digit` = 0. Otherwise `sel` = 1 << `idx`.
- `digit`, `sel` and `blank` are decoded only from registered `idx` and `act`. There is no combinational path from `load` or `din` to any output.

## Timing
- Reset (synchronous, takes priority over `load`):
  - `cnt` = 0, `idx` = 0, `act` = 0, `pend` = 0, `pend_v` = 0, `frame_done` = 0.
  - Outputs in the first cycle after reset: `digit` = 0, `sel` = 4'b0001, `blank` = 0, `pending` = 0, `frame_done` = 0.
- Each digit is active for exactly DIV cycles. A full frame is 4·DIV cycles.
- `sel` and `digit` change on the same clock edge, on the edge that ends a slot.
- Latency from a load accepted at cycle t to the new value on the display:
  - The new value appears on the edge after the next `wrap` at or after t.
  - Worst case: 4·DIV cycles after t.
  - Load on a wrap cycle: visible on the next edge, starting at digit 0.
- `pending` rises on the edge after `load` and falls on the edge after the transferring `wrap`.
- Reset asserted mid-frame or with `pend_v` = 1: all state returns to reset values on the next edge and the pending value is lost.

## Test plan
- Reset and scan, DIV=4, `din`=16'h1234 loaded then reset released → after one wrap, `sel` steps 0001/0010/0100/1000, each held 4 cycles; `digit` steps 4/3/2/1; `frame_done` pulses once every 16 cycles.
- Tear-free update: load 16'h5678 while `idx`=1, then load 16'h9012 two cycles later → the current frame finishes showing 1234; `pending`=1 until the wrap; the next frame shows 2/1/0/9; 5678 is never displayed.
- Load coincident with wrap: pulse `load` with `din`=16'h0042 exactly on the `wrap` cycle → the next edge shows `digit`=2 with `sel`=0001, and `pending` stays 0.
- Leading-zero blanking, `act`=16'h0042 → digits 0 and 1 show 2 and 4; digits 2 and 3 have `blank`=1 and `sel`=0000. With `act`=16'h0000 → only digit 0 unblanked, showing 0. With `act`=16'h1000 → no digit blanked, inner zeros shown.
- Invalid BCD, `act`=16'h3A05 → slot 2 has `blank`=1, `sel`=0000, `digit`=0; slot 3 shows 3; slot 1 shows 0 (not leading, since the more-significant nibbles are non-zero).
- Reset mid-operation: assert `reset` for 1 cycle with `pend_v`=1 and `idx`=2 → next cycle `sel`=0001, `digit`=0, `pending`=0; the pending value is never displayed.
